dmem_responder: RTL

- Responder end of the processor's data-memory interface: accepts one load/store request at a time from the core's memory stage over a valid/ready handshake.
- Inserts a configurable number of wait states, then performs the access on a word-organised RAM.
- Returns the result (load data with sign/zero extension, or store acknowledge) on a valid/ready response channel.
- Replaces the ideal single-cycle data memory when the core moves to a stall-capable memory stage.

---
 rtl/dmem_pkg.sv | 40 ++++
 rtl/dmem_lane_align.sv | 44 ++++
 rtl/dmem_responder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared funct3 codes, FSM encoding and byte-lane helpers for
//                the data-memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_LANE_B = 4'b0001;
    localparam logic [3:0] c_LANE_H = 4'b0011;
    localparam logic [3:0] c_LANE_W = 4'b1111;

    // Byte-enable for an access of the given size (funct3[1:0]) at a byte offset.
    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'b00:   m = c_LANE_B << off;
            2'b01:   m = c_LANE_H << {off[1], 1'b0};
            default: m = c_LANE_W;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
//  Module      : dmem_lane_align
//  Description : Combinational byte-lane steering: store merge into the old
//                word and load extraction with sign/zero extension.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_byte_off,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_byte_mask,
    output logic [31:0] o_merged,
    output logic [31:0] o_load_data
);

    logic [31:0] w_wdata_sh;
    logic [31:0] w_rd_sh;

    always_comb begin
        w_wdata_sh = i_wdata << {i_byte_off, 3'b000};
        w_rd_sh    = i_old_word >> {i_byte_off, 3'b000};
        o_merged   = i_old_word;
        for (int i = 0; i < 4; i++) begin
            if (i_byte_mask[i]) begin
                o_merged[8*i +: 8] = w_wdata_sh[8*i +: 8];
            end
        end
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_rd_sh[7]}}, w_rd_sh[7:0]};
            F3_H:    o_load_data = {{16{w_rd_sh[15]}}, w_rd_sh[15:0]};
            F3_BU:   o_load_data = {24'd0, w_rd_sh[7:0]};
            F3_HU:   o_load_data = {16'd0, w_rd_sh[15:0]};
            default: o_load_data = w_rd_sh;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
//  Module      : dmem_responder
//  Description : Valid/ready data-memory responder with programmable wait
//                states over a word RAM. Define DMEM_RESET_CLEAR_EN to zero
//                the array after reset before the first request is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int             c_AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]     c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [c_AW-1:0] c_LAST_IDX = c_AW'(DEPTH_WORDS - 1);

    logic [31:0] r_mem [DEPTH_WORDS];

    state_t          r_state_q, w_state_d;
    logic [3:0]      r_cnt_q, w_cnt_d;
    logic [c_AW-1:0] r_idx_q, w_idx_d;
    logic [1:0]      r_off_q, w_off_d;
    logic [31:0]     r_wdata_q, w_wdata_d;
    logic            r_we_q, w_we_d;
    logic [2:0]      r_f3_q, w_f3_d;
    logic            r_cerr_q, w_cerr_d;
    logic [31:0]     r_rdata_q, w_rdata_d;
    logic            r_err_q, w_err_d;
    logic            r_init_q, w_init_d;

    logic            w_f3_bad, w_misalign, w_range, w_req_err;
    logic            w_access;
    logic [c_AW-1:0] w_acc_idx;
    logic [1:0]      w_acc_off;
    logic [31:0]     w_acc_wdata;
    logic            w_acc_we, w_acc_err;
    logic [2:0]      w_acc_f3;
    logic [31:0]     w_merged, w_load_data;
    logic            w_wr_en;
    logic [c_AW-1:0] w_wr_idx;
    logic [31:0]     w_wr_data;

    assign req_ready = (r_state_q == ST_IDLE) && r_init_q;
    assign rsp_valid = (r_state_q == ST_RESP);
    assign rsp_rdata = r_rdata_q;
    assign rsp_err   = r_err_q;

    always_comb begin
        if (req_we) begin
            w_f3_bad = !(req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W);
        end else begin
            w_f3_bad = !(req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W ||
                         req_funct3 == F3_BU || req_funct3 == F3_HU);
        end
        w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        w_range    = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
        w_req_err  = w_f3_bad || w_misalign || w_range;
    end

    // With zero wait states the access happens on the accepting edge itself,
    // so the live request fields feed the array instead of the captured ones.
    always_comb begin
        if (r_state_q == ST_IDLE) begin
            w_acc_idx   = req_addr[c_AW+1:2];
            w_acc_off   = req_addr[1:0];
            w_acc_wdata = req_wdata;
            w_acc_we    = req_we;
            w_acc_f3    = req_funct3;
            w_acc_err   = w_req_err;
        end else begin
            w_acc_idx   = r_idx_q;
            w_acc_off   = r_off_q;
            w_acc_wdata = r_wdata_q;
            w_acc_we    = r_we_q;
            w_acc_f3    = r_f3_q;
            w_acc_err   = r_cerr_q;
        end
    end

    dmem_lane_align u_lane_align (
        .i_funct3    (w_acc_f3),
        .i_byte_off  (w_acc_off),
        .i_old_word  (r_mem[w_acc_idx]),
        .i_wdata     (w_acc_wdata),
        .i_byte_mask (byte_mask(w_acc_f3[1:0], w_acc_off)),
        .o_merged    (w_merged),
        .o_load_data (w_load_data)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_idx_d   = r_idx_q;
        w_off_d   = r_off_q;
        w_wdata_d = r_wdata_q;
        w_we_d    = r_we_q;
        w_f3_d    = r_f3_q;
        w_cerr_d  = r_cerr_q;
        w_rdata_d = r_rdata_q;
        w_err_d   = r_err_q;
        w_access  = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    w_idx_d   = req_addr[c_AW+1:2];
                    w_off_d   = req_addr[1:0];
                    w_wdata_d = req_wdata;
                    w_we_d    = req_we;
                    w_f3_d    = req_funct3;
                    w_cerr_d  = w_req_err;
                    if (WAIT_STATES > 0) begin
                        w_state_d = ST_WAIT;
                        w_cnt_d   = c_WAIT_LOAD;
                    end else begin
                        w_state_d = ST_RESP;
                        w_access  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt_q == 4'd0) begin
                    w_state_d = ST_RESP;
                    w_access  = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
        if (w_access) begin
            w_err_d   = w_acc_err;
            w_rdata_d = (w_acc_err || w_acc_we) ? 32'd0 : w_load_data;
        end
    end

`ifdef DMEM_RESET_CLEAR_EN
    logic [c_AW-1:0] r_clr_ptr_q, w_clr_ptr_d;

    always_comb begin
        w_clr_ptr_d = r_clr_ptr_q;
        w_init_d    = r_init_q;
        w_wr_en     = !reset && w_access && w_acc_we && !w_acc_err;
        w_wr_idx    = w_acc_idx;
        w_wr_data   = w_merged;
        if (!r_init_q) begin
            w_clr_ptr_d = r_clr_ptr_q + 1'b1;
            w_init_d    = (r_clr_ptr_q == c_LAST_IDX);
            w_wr_en     = !reset;
            w_wr_idx    = r_clr_ptr_q;
            w_wr_data   = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clr_ptr_q <= '0;
        end else begin
            r_clr_ptr_q <= w_clr_ptr_d;
        end
    end
`else
    always_comb begin
        w_init_d  = 1'b1;
        w_wr_en   = !reset && w_access && w_acc_we && !w_acc_err;
        w_wr_idx  = w_acc_idx;
        w_wr_data = w_merged;
    end
`endif

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= w_wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= 4'd0;
            r_idx_q   <= '0;
            r_off_q   <= 2'd0;
            r_wdata_q <= 32'd0;
            r_we_q    <= 1'b0;
            r_f3_q    <= 3'd0;
            r_cerr_q  <= 1'b0;
            r_rdata_q <= 32'd0;
            r_err_q   <= 1'b0;
            r_init_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_idx_q   <= w_idx_d;
            r_off_q   <= w_off_d;
            r_wdata_q <= w_wdata_d;
            r_we_q    <= w_we_d;
            r_f3_q    <= w_f3_d;
            r_cerr_q  <= w_cerr_d;
            r_rdata_q <= w_rdata_d;
            r_err_q   <= w_err_d;
            r_init_q  <= w_init_d;
        end
    end

endmodule

`default_nettype wire
